// File: rtl/imem_prog.sv
// ---------------------------------------------------------------------------
// imem_prog -- loadable instruction memory for the ASIP fetch stage.
//
// After reset a CLEAR sweep zeroes every word (all-zero encodes a NOP). In
// PROG the loader port writes one word per cycle. In RUN the block serves
// registered, stallable fetches at byte-addressed PCs. It flags misaligned
// and out-of-range fetches and returns 0 for them.
//
// Parameters
//   DATA_W  instruction word width
//   PC_W    fetch (byte) address width
//   DEPTH   number of words, DEPTH <= 2**(PC_W-2)
//   AW      word-index width, derived from DEPTH
//
// Ports
//   clk          in   system clock, rising edge
//   reset        in   asynchronous, active-high reset
//   prog_en      in   request program mode
//   prog_we      in   write strobe, honoured only in PROG
//   prog_addr    in   word index to write
//   prog_data    in   word to write
//   fetch_req    in   fetch request, honoured only in RUN
//   fetch_addr   in   byte address (PC)
//   stall        in   hold fetch outputs, ignore fetch_req
//   fetch_data   out  fetched instruction
//   fetch_valid  out  fetch_data/fetch_fault belong to an accepted request
//   fetch_fault  out  accepted fetch was misaligned or out of range
//   ready        out  high while in RUN
//   mode         out  state: 0 CLEAR, 1 PROG, 2 RUN
//
// Handshake: a fetch is accepted at a rising edge where the block is in RUN,
// prog_en=0, fetch_req=1 and stall=0. The result is on the outputs one cycle
// later. stall=1 freezes fetch_data/fetch_valid/fetch_fault in every state.
// ---------------------------------------------------------------------------
module imem_prog #(
    parameter  int DATA_W = 17,
    parameter  int PC_W   = 8,
    parameter  int DEPTH  = 64,
    localparam int AW     = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              prog_en,
    input  logic              prog_we,
    input  logic [AW-1:0]     prog_addr,
    input  logic [DATA_W-1:0] prog_data,
    input  logic              fetch_req,
    input  logic [PC_W-1:0]   fetch_addr,
    input  logic              stall,
    output logic [DATA_W-1:0] fetch_data,
    output logic              fetch_valid,
    output logic              fetch_fault,
    output logic              ready,
    output logic [1:0]        mode
);

    typedef enum logic [1:0] {
        ST_CLEAR = 2'd0,
        ST_PROG  = 2'd1,
        ST_RUN   = 2'd2
    } state_t;

    localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);

    state_t            state;
    state_t            state_next;
    logic [AW-1:0]     clr_cnt;
    logic [DATA_W-1:0] mem [DEPTH];

    // Fetch decode
    logic [PC_W-3:0] index;
    logic            misaligned;
    logic            oor;
    logic            fault;
    logic            accept;
    logic            wr_ok;

    assign index      = fetch_addr[PC_W-1:2];
    assign misaligned = (fetch_addr[1:0] != 2'b00);
    assign oor        = (32'(index) >= 32'(DEPTH));
    assign fault      = misaligned | oor;

    // A fetch seen on the same edge that RUN leaves for PROG is dropped.
    assign accept = (state == ST_RUN) && !prog_en && fetch_req && !stall;

    // Writes beyond DEPTH are only reachable for non-power-of-two depths.
    assign wr_ok = (state == ST_PROG) && prog_we &&
                   (32'(prog_addr) < 32'(DEPTH));

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= ST_CLEAR;
            clr_cnt <= '0;
        end else begin
            state <= state_next;
            if (state == ST_CLEAR) begin
                clr_cnt <= clr_cnt + AW'(1);
            end else begin
                clr_cnt <= '0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_next = state;
        case (state)
            ST_CLEAR: begin
                if (clr_cnt == LAST_IDX) begin
                    state_next = prog_en ? ST_PROG : ST_RUN;
                end
            end
            ST_PROG: begin
                if (!prog_en) begin
                    state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                if (prog_en) begin
                    state_next = ST_PROG;
                end
            end
            default: state_next = ST_CLEAR;
        endcase
    end

    // ------------------------------------------------------------------
    // Storage: no reset of its own, the CLEAR sweep zeroes it.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (state == ST_CLEAR) begin
            mem[clr_cnt] <= '0;
        end else if (wr_ok) begin
            mem[prog_addr] <= prog_data;
        end
    end

    // ------------------------------------------------------------------
    // Registered fetch outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetch_data  <= '0;
            fetch_valid <= 1'b0;
            fetch_fault <= 1'b0;
        end else if (!stall) begin
            if (accept) begin
                fetch_data  <= fault ? '0 : mem[index[AW-1:0]];
                fetch_valid <= 1'b1;
                fetch_fault <= fault;
            end else begin
                // fetch_data keeps the last fetched word
                fetch_valid <= 1'b0;
                fetch_fault <= 1'b0;
            end
        end
    end

    assign ready = (state == ST_RUN);
    assign mode  = state;

endmodule

// File: tb/tb_imem_prog.sv
// ---------------------------------------------------------------------------
// tb_imem_prog -- self-checking bench for imem_prog.
// Two instances share every input: dut_a (DEPTH=64) and dut_b (DEPTH=32).
// dut_b gets only the low 5 bits of prog_addr, so loader writes alias
// modulo 32 in it. dut_b covers the out-of-range fetch path.
// ---------------------------------------------------------------------------
module tb_imem_prog;

    localparam int DATA_W  = 17;
    localparam int PC_W    = 8;
    localparam int DEPTH_A = 64;
    localparam int DEPTH_B = 32;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic              prog_en;
    logic              prog_we;
    logic [5:0]        prog_addr;
    logic [DATA_W-1:0] prog_data;
    logic              fetch_req;
    logic [PC_W-1:0]   fetch_addr;
    logic              stall;

    logic [DATA_W-1:0] a_data, b_data;
    logic              a_valid, b_valid, a_fault, b_fault, a_ready, b_ready;
    logic [1:0]        a_mode, b_mode;

    imem_prog #(.DATA_W(DATA_W), .PC_W(PC_W), .DEPTH(DEPTH_A)) dut_a (
        .clk(clk), .reset(reset), .prog_en(prog_en), .prog_we(prog_we),
        .prog_addr(prog_addr), .prog_data(prog_data),
        .fetch_req(fetch_req), .fetch_addr(fetch_addr), .stall(stall),
        .fetch_data(a_data), .fetch_valid(a_valid), .fetch_fault(a_fault),
        .ready(a_ready), .mode(a_mode)
    );

    imem_prog #(.DATA_W(DATA_W), .PC_W(PC_W), .DEPTH(DEPTH_B)) dut_b (
        .clk(clk), .reset(reset), .prog_en(prog_en), .prog_we(prog_we),
        .prog_addr(prog_addr[4:0]), .prog_data(prog_data),
        .fetch_req(fetch_req), .fetch_addr(fetch_addr), .stall(stall),
        .fetch_data(b_data), .fetch_valid(b_valid), .fetch_fault(b_fault),
        .ready(b_ready), .mode(b_mode)
    );

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_errors = 0;
    logic [DATA_W-1:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    logic [DATA_W-1:0] mem_a [DEPTH_A];
    logic [DATA_W-1:0] mem_b [DEPTH_B];

    task automatic model_clear();
        foreach (mem_a[i]) mem_a[i] = '0;
        foreach (mem_b[i]) mem_b[i] = '0;
    endtask

    task automatic model_write(input int idx, input logic [DATA_W-1:0] d);
        mem_a[idx]      = d;
        mem_b[idx % 32] = d;
    endtask

    function automatic logic fault_of(input logic [7:0] a, input int depth);
        return (a % 4 != 0) || ((int'(a) / 4) >= depth);
    endfunction

    function automatic logic [DATA_W-1:0] word_a(input logic [7:0] a);
        if (fault_of(a, DEPTH_A)) return '0;
        return mem_a[int'(a) / 4];
    endfunction

    function automatic logic [DATA_W-1:0] word_b(input logic [7:0] a);
        if (fault_of(a, DEPTH_B)) return '0;
        return mem_b[int'(a) / 4];
    endfunction

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_word(input int idx, input logic [DATA_W-1:0] d);
        prog_we   = 1'b1;
        prog_addr = 6'(idx);
        prog_data = d;
        tick();
        prog_we   = 1'b0;
        model_write(idx, d);
    endtask

    task automatic fetch(input logic [7:0] a);
        fetch_req  = 1'b1;
        fetch_addr = a;
        tick();
        fetch_req  = 1'b0;
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic [7:0]        addr;
        logic              req;
        logic              stl;
        logic [DATA_W-1:0] data;
        logic              valid;
        logic              fault;
    } vec_t;

    vec_t vecs[16];

    // ---------------- main test ----------------
    initial begin
        logic [DATA_W-1:0] ea_data, eb_data;
        logic              e_valid, ea_fault, eb_fault;
        int                cnt;

        vecs[0]  = '{8'h08, 1'b1, 1'b0, 17'h04E17, 1'b1, 1'b0};
        vecs[1]  = '{8'h00, 1'b1, 1'b0, 17'h01EFF, 1'b1, 1'b0};
        vecs[2]  = '{8'h04, 1'b1, 1'b0, 17'h04E22, 1'b1, 1'b0};
        vecs[3]  = '{8'h08, 1'b1, 1'b0, 17'h04E17, 1'b1, 1'b0};
        vecs[4]  = '{8'h05, 1'b1, 1'b0, 17'h00000, 1'b1, 1'b1};
        vecs[5]  = '{8'h04, 1'b1, 1'b0, 17'h04E22, 1'b1, 1'b0};
        vecs[6]  = '{8'h00, 1'b0, 1'b0, 17'h04E22, 1'b0, 1'b0};
        vecs[7]  = '{8'h04, 1'b1, 1'b0, 17'h04E22, 1'b1, 1'b0};
        vecs[8]  = '{8'h08, 1'b1, 1'b1, 17'h04E22, 1'b1, 1'b0};
        vecs[9]  = '{8'h08, 1'b1, 1'b1, 17'h04E22, 1'b1, 1'b0};
        vecs[10] = '{8'h08, 1'b1, 1'b1, 17'h04E22, 1'b1, 1'b0};
        vecs[11] = '{8'h08, 1'b1, 1'b0, 17'h04E17, 1'b1, 1'b0};
        vecs[12] = '{8'h0C, 1'b1, 1'b0, 17'h00000, 1'b1, 1'b0};
        vecs[13] = '{8'hFE, 1'b1, 1'b0, 17'h00000, 1'b1, 1'b1};
        vecs[14] = '{8'h00, 1'b0, 1'b1, 17'h00000, 1'b1, 1'b1};
        vecs[15] = '{8'h00, 1'b0, 1'b0, 17'h00000, 1'b0, 1'b0};

        reset = 1'b0; prog_en = 1'b0; prog_we = 1'b0; prog_addr = '0;
        prog_data = '0; fetch_req = 1'b0; fetch_addr = '0; stall = 1'b0;
        #1 reset = 1'b1;
        tick(); tick();
        check("rst_data", 32'(a_data), 0);
        check("rst_valid", 32'(a_valid), 0);
        check("rst_fault", 32'(a_fault), 0);
        check("rst_ready", 32'(a_ready), 0);
        check("rst_mode", 32'(a_mode), 0);
        model_clear();

        // ---- reset sweep: ready exactly DEPTH edges after release ----
        #5 reset = 1'b0;
        for (int i = 1; i <= DEPTH_A; i++) begin
            tick();
            check("sweep_ready_a", 32'(a_ready), (i == DEPTH_A) ? 1 : 0);
            check("sweep_mode_a", 32'(a_mode), (i == DEPTH_A) ? 2 : 0);
            check("sweep_ready_b", 32'(b_ready), (i >= DEPTH_B) ? 1 : 0);
        end
        fetch(8'h00);
        check("first_data", 32'(a_data), 0);
        check("first_valid", 32'(a_valid), 1);
        check("first_fault", 32'(a_fault), 0);

        // ---- program mode; fetch on the RUN->PROG edge is dropped ----
        prog_en    = 1'b1;
        fetch_req  = 1'b1;
        fetch_addr = 8'h00;
        tick();
        check("enter_prog_mode", 32'(a_mode), 1);
        check("enter_prog_valid", 32'(a_valid), 0);
        write_word(0, 17'h01EFF);
        check("prog_fetch_valid", 32'(a_valid), 0);
        write_word(1, 17'h04E22);
        prog_en = 1'b0;  // last PROG edge also carries a write
        write_word(2, 17'h04E17);
        fetch_req = 1'b0;
        check("run_ready", 32'(a_ready), 1);
        check("run_mode", 32'(a_mode), 2);

        // ---- table-driven fetch vectors ----
        foreach (vecs[i]) begin
            fetch_addr = vecs[i].addr;
            fetch_req  = vecs[i].req;
            stall      = vecs[i].stl;
            tick();
            check($sformatf("vec%0d_data", i), 32'(a_data), 32'(vecs[i].data));
            check($sformatf("vec%0d_valid", i), 32'(a_valid), 32'(vecs[i].valid));
            check($sformatf("vec%0d_fault", i), 32'(a_fault), 32'(vecs[i].fault));
        end
        fetch_req = 1'b0;
        stall     = 1'b0;

        // ---- out of range on the 32-word instance ----
        fetch(8'h80);
        check("oor_b_fault", 32'(b_fault), 1);
        check("oor_b_data", 32'(b_data), 0);
        check("oor_b_valid", 32'(b_valid), 1);
        check("oor_a_fault", 32'(a_fault), 0);
        fetch(8'h04);
        check("after_oor_b_fault", 32'(b_fault), 0);
        check("after_oor_b_data", 32'(b_data), 32'h04E22);

        // ---- writes in RUN are ignored ----
        write_word(0, 17'h1FFFF);
        model_write(0, 17'h01EFF);
        fetch(8'h00);
        check("run_we_ignored_a", 32'(a_data), 32'h01EFF);
        check("run_we_ignored_b", 32'(b_data), 32'h01EFF);

        // ---- randomized program + fetch against the model ----
        prog_en = 1'b1;
        tick();
        write_word(0, 17'h0ABCD);
        for (int i = 0; i < 24; i++) begin
            write_word($urandom_range(1, DEPTH_A - 1), DATA_W'($urandom));
        end
        prog_en = 1'b0;
        tick();
        fetch(8'h00);
        check("rand_seed_a", 32'(a_data), 32'(word_a(8'h00)));
        ea_data = word_a(8'h00); eb_data = word_b(8'h00);
        e_valid = 1'b1; ea_fault = 1'b0; eb_fault = 1'b0;
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                fetch_addr = 8'($urandom);
            end else begin
                fetch_addr = 8'($urandom_range(0, DEPTH_A - 1) * 4);
            end
            fetch_req = ($urandom_range(0, 4) != 0);
            stall     = ($urandom_range(0, 3) == 0);
            if (!stall) begin
                if (fetch_req) begin
                    ea_data  = word_a(fetch_addr);
                    eb_data  = word_b(fetch_addr);
                    ea_fault = fault_of(fetch_addr, DEPTH_A);
                    eb_fault = fault_of(fetch_addr, DEPTH_B);
                    e_valid  = 1'b1;
                end else begin
                    ea_fault = 1'b0;
                    eb_fault = 1'b0;
                    e_valid  = 1'b0;
                end
            end
            exp_q.push_back(ea_data);
            tick();
            check("rnd_a_data", 32'(a_data), 32'(exp_q.pop_front()));
            check("rnd_a_valid", 32'(a_valid), 32'(e_valid));
            check("rnd_a_fault", 32'(a_fault), 32'(ea_fault));
            check("rnd_b_data", 32'(b_data), 32'(eb_data));
            check("rnd_b_fault", 32'(b_fault), 32'(eb_fault));
        end
        fetch_req = 1'b0;
        stall     = 1'b0;

        // ---- asynchronous reset in the middle of PROG ----
        fetch(8'h00);
        check("pre_reset_data", 32'(a_data), 32'h0ABCD);
        prog_en = 1'b1;
        tick();
        write_word(0, 17'h00111);
        write_word(1, 17'h00222);
        #2 reset = 1'b1;
        #1;
        check("async_rst_data", 32'(a_data), 0);
        check("async_rst_mode", 32'(a_mode), 0);
        check("async_rst_ready", 32'(a_ready), 0);
        check("async_rst_valid", 32'(a_valid), 0);
        model_clear();
        prog_en = 1'b0;
        #3 reset = 1'b0;

        // ---- second reset at sweep cycle 10 restarts the sweep ----
        for (int i = 0; i < 10; i++) tick();
        #2 reset = 1'b1;
        #1;
        check("mid_sweep_mode", 32'(a_mode), 0);
        #3 reset = 1'b0;
        cnt = 0;
        while (!a_ready && cnt < 200) begin
            tick();
            cnt++;
        end
        check("sweep_len", 32'(cnt), 64);
        fetch(8'h04);
        check("cleared_word1", 32'(a_data), 32'(word_a(8'h04)));
        check("cleared_valid", 32'(a_valid), 1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    // Global time limit so the bench always terminates.
    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        n_errors++;
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/imem_prog.md
# imem_prog

Parametrised, loadable instruction memory for the ASIP fetch stage, replacing the fixed combinational ROM. After reset it clears every word to zero, which encodes a NOP. In program mode it accepts word writes from the loader port. In run mode it serves registered, stallable fetches at byte-addressed, word-aligned PCs, and flags misaligned or out-of-range fetches.

## Interface
Parameters:
- DATA_W, 17, instruction word width.
- PC_W, 8, fetch (byte) address width.
- DEPTH, 64, number of instruction words; must satisfy DEPTH ≤ 2^(PC_W-2).
- AW, $clog2(DEPTH), word-index width (derived, not overridden).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- prog_en  in  1  request program mode.
- prog_we  in  1  write strobe, honoured only in PROG.
- prog_addr  in  AW  word index to write.
- prog_data  in  DATA_W  word to write.
- fetch_req  in  1  fetch request, honoured only in RUN.
- fetch_addr  in  PC_W  byte address (PC).
- stall  in  1  hold fetch outputs, ignore fetch_req.
- fetch_data  out  DATA_W  fetched instruction.
- fetch_valid  out  1  fetch_data/fetch_fault are for an accepted request.
- fetch_fault  out  1  accepted fetch was misaligned or out of range.
- ready  out  1  high while in RUN.
- mode  out  2  state: 0 CLEAR, 1 PROG, 2 RUN.

## Operation
- Storage: DEPTH × DATA_W registers, synchronous write, registered read. Contents are not reset directly; the CLEAR sweep zeroes them.
- FSM states and transitions:
  - CLEAR: on entry clr_cnt=0. Each cycle writes 0 to word clr_cnt, then increments. After writing word DEPTH-1, goes to PROG if prog_en=1, otherwise to RUN. Takes exactly DEPTH cycles.
  - PROG: while prog_we=1, mem[prog_addr] ← prog_data at each edge. Goes to RUN on the first edge with prog_en=0.
  - RUN: goes to PROG on the first edge with prog_en=1. Any fetch sampled at that same edge is not accepted.
- Fetch decode: index = fetch_addr[PC_W-1:2].
  - misaligned = fetch_addr[1:0] ≠ 0.
  - oor = index ≥ DEPTH.
  - fault = misaligned | oor.
- Accepted fetch: state RUN, fetch_req=1, stall=0 at an edge.
  - Next fetch_data = fault ? 0 : mem[index].
  - fetch_fault = fault; fetch_valid = 1.
- stall=1 (any state): fetch_data, fetch_valid and fetch_fault hold their values. fetch_req is ignored.
- State RUN, fetch_req=0, stall=0: fetch_valid → 0, fetch_fault → 0, fetch_data holds.
- Outside RUN with stall=0: fetch_valid and fetch_fault → 0 one cycle after leaving RUN. fetch_data holds.
- Ignored writes: prog_we outside PROG is ignored. A write with prog_addr ≥ DEPTH (possible when DEPTH is not a power of two) is ignored.
- Reset (asynchronous, including mid-sweep, mid-PROG or mid-fetch):
  - State → CLEAR, clr_cnt → 0.
  - fetch_data → 0, fetch_valid → 0, fetch_fault → 0, ready → 0, mode → 0.
  - The full sweep always restarts after reset.

## Timing
- Reset release to ready=1: exactly DEPTH rising edges when prog_en=0.
- Fetch latency: 1 cycle. A request accepted at edge N appears on the outputs after edge N and stays stable until edge N+1.
- Back-to-back fetches: one per cycle, no bubbles.
- Program-to-run: a word written at the last PROG edge is visible to the first RUN fetch, one edge later.
- No read-during-write in RUN, because writes occur only in CLEAR or PROG.
- ready and mode are registered state outputs with no combinational path from the inputs.

## Test plan
- Reset sweep (DEPTH=64, prog_en=0): release reset → mode=0 and ready=0 for 64 edges, then ready=1 and mode=2. Fetch 0x00 → next cycle fetch_data=0, fetch_valid=1, fetch_fault=0.
- Program then run:
  - Set prog_en=1.
  - Write idx0=17'h01EFF, idx1=17'h04E22, idx2=17'h04E17.
  - Drop prog_en.
  - Fetch 0x00, 0x04, 0x08 back-to-back → 17'h01EFF, 17'h04E22, 17'h04E17 on consecutive cycles, fetch_valid=1 throughout.
- Faults:
  - Fetch 0x05 → fetch_data=0, fetch_valid=1, fetch_fault=1.
  - With DEPTH=32, fetch 0x80 → fetch_fault=1, fetch_data=0.
  - Following fetch 0x04 → fetch_fault=0.
- Stall: accept fetch 0x04, then hold stall=1 for 3 cycles while fetch_addr=0x08 and fetch_req=1 → fetch_data stays at word1 with fetch_valid=1. Release stall → word2 appears on the next cycle.
- Mode guards:
  - prog_we=1 in RUN (idx0=17'h1FFFF) → fetch 0x00 still returns the old value.
  - fetch_req in PROG → fetch_valid=0.
- Reset mid-operation:
  - Assert reset during PROG after writing idx1 → outputs 0 immediately, without waiting for a clock edge.
  - After the 64-cycle sweep, fetch 0x04 → 0.
  - Reset at sweep cycle 10 → ready rises 64 edges after release.
